// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported 256x16 memory between instruction fetch
//            and the MEM stage: data-first priority with a fetch starvation
//            guard, read sequencing, and per-requester stall generation.
//            Optional perf counters are enabled by defining ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [7:0]  dm_addr,
    input  logic [7:0]  dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [7:0]  dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [15:0] perf_if_grants,
    output logic [15:0] perf_dm_grants,
    output logic [15:0] perf_conflicts
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  lat_q, lat_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [7:0]  dm_rdata_q, dm_rdata_d;
    logic        grant_if, grant_dm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            lat_q      <= 3'd0;
            addr_q     <= 8'd0;
            if_rdata_q <= 16'd0;
            dm_rdata_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        if_rvalid  = 1'b0;
        dm_rvalid  = 1'b0;
        if_rdata   = if_rdata_q;
        dm_rdata   = dm_rdata_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = 16'd0;

        case (state_q)
            IDLE: begin
                // Gated by reset so no grant leaks out while reset is held.
                if (reset) begin
                    if (dm_req && !(if_req && (starve_q == STARVE_MAX))) begin
                        grant_dm = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (lat_q == 3'd0) begin
                    state_d = IDLE;
                    if (state_q == BUSY_IF) begin
                        if_rvalid  = 1'b1;
                        if_rdata   = mem_rdata;
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_rvalid  = 1'b1;
                        dm_rdata   = mem_rdata[7:0];
                        dm_rdata_d = mem_rdata[7:0];
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_dm) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = {8'h00, dm_wdata};
            addr_d    = dm_addr;
            if (!dm_we) begin
                state_d = BUSY_DM;
                lat_d   = LAT_INIT;
            end
        end else if (grant_if) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            addr_d   = if_addr;
            state_d  = BUSY_IF;
            lat_d    = LAT_INIT;
        end

        if (!if_req || grant_if) begin
            starve_d = 4'd0;
        end else if (grant_dm && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign stall_if  = reset & if_req & ~if_rvalid;
    assign stall_mem = reset & dm_req & ~(dm_rvalid | (grant_dm & dm_we));

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_if_q, perf_if_d;
    logic [15:0] perf_dm_q, perf_dm_d;
    logic [15:0] perf_cf_q, perf_cf_d;

    always_comb begin
        perf_if_d = perf_if_q;
        perf_dm_d = perf_dm_q;
        perf_cf_d = perf_cf_q;
        if (grant_if && (perf_if_q != 16'hFFFF)) perf_if_d = perf_if_q + 16'd1;
        if (grant_dm && (perf_dm_q != 16'hFFFF)) perf_dm_d = perf_dm_q + 16'd1;
        if ((state_q == IDLE) && if_req && dm_req && (perf_cf_q != 16'hFFFF)) begin
            perf_cf_d = perf_cf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_q <= 16'd0;
            perf_dm_q <= 16'd0;
            perf_cf_q <= 16'd0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_dm_grants = perf_dm_q;
    assign perf_conflicts = perf_cf_q;
`else
    assign perf_if_grants = 16'd0;
    assign perf_dm_grants = 16'd0;
    assign perf_conflicts = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Testbench for mem_port_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [7:0]  if_addr, dm_addr, dm_wdata;

    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_if, stall_mem;
    logic [15:0] if_rdata, mem_wdata, perf_if_grants, perf_dm_grants, perf_conflicts;
    logic [7:0]  dm_rdata, mem_addr;
    logic [15:0] mem_rdata = 16'd0;

    logic        u3_if_gnt, u3_if_rvalid, u3_dm_gnt, u3_dm_rvalid, u3_mem_en, u3_mem_we;
    logic        u3_stall_if, u3_stall_mem;
    logic [15:0] u3_if_rdata, u3_mem_wdata, u3_perf_if, u3_perf_dm, u3_perf_cf;
    logic [7:0]  u3_dm_rdata, u3_mem_addr;
    logic [15:0] u3_s1 = 16'd0, u3_s2 = 16'd0, u3_mem_rdata = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants), .perf_conflicts(perf_conflicts)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(LIMIT)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(u3_if_gnt), .if_rvalid(u3_if_rvalid), .if_rdata(u3_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(u3_dm_gnt), .dm_rvalid(u3_dm_rvalid), .dm_rdata(u3_dm_rdata),
        .mem_en(u3_mem_en), .mem_we(u3_mem_we), .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata),
        .mem_rdata(u3_mem_rdata), .stall_if(u3_stall_if), .stall_mem(u3_stall_mem),
        .perf_if_grants(u3_perf_if), .perf_dm_grants(u3_perf_dm), .perf_conflicts(u3_perf_cf)
    );

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory environments: 1-cycle array for u_dut, 3-stage read-only pipe for u_dut3.
    logic [15:0] mem1 [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        mem_rdata      <= mem1[mem_addr];
        end
    end
    always @(posedge clk) begin
        if (u3_mem_en) u3_s1 <= pat(u3_mem_addr);
        u3_s2        <= u3_s1;
        u3_mem_rdata <= u3_s2;
    end

    // Reference model state (transaction level).
    logic [15:0] ref_mem [256];
    int          cyc = 0, free_at = 0, due = 0, starve = 0;
    bit          pend = 0, pend_if = 0;
    logic [15:0] pend_data = 16'd0, last_if = 16'd0;
    logic [7:0]  last_dm = 8'd0;
    int          p_if = 0, p_dm = 0, p_cf = 0;

    always @(negedge clk) begin : cmp
        logic       idle, e_ig, e_dg, e_irv, e_drv;
        logic [7:0] e_addr;
        if (!reset) begin
            check("reset_outputs", 64'({if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en,
                  mem_we, mem_addr, mem_wdata, stall_if, stall_mem}), 64'd0);
            check("reset_perf", 64'({perf_if_grants, perf_dm_grants, perf_conflicts}), 64'd0);
            pend = 0; free_at = cyc + 1; starve = 0; last_if = 16'd0; last_dm = 8'd0;
            p_if = 0; p_dm = 0; p_cf = 0;
        end else begin
            idle = (cyc >= free_at);
            e_ig = 1'b0; e_dg = 1'b0; e_addr = 8'd0;
            if (idle) begin
                if (dm_req && !(if_req && starve == LIMIT)) begin e_dg = 1'b1; e_addr = dm_addr; end
                else if (if_req) begin e_ig = 1'b1; e_addr = if_addr; end
            end
            e_irv = pend && pend_if && (cyc == due);
            e_drv = pend && !pend_if && (cyc == due);
            if (e_irv) last_if = pend_data;
            if (e_drv) last_dm = pend_data[7:0];

            check("if_gnt", 64'(if_gnt), 64'(e_ig));
            check("dm_gnt", 64'(dm_gnt), 64'(e_dg));
            check("mem_en", 64'(mem_en), 64'(e_ig | e_dg));
            check("mem_we", 64'(mem_we), 64'(e_dg & dm_we));
            if (e_ig | e_dg) check("mem_addr", 64'(mem_addr), 64'(e_addr));
            if (e_dg & dm_we) check("mem_wdata", 64'(mem_wdata), 64'({8'h00, dm_wdata}));
            check("if_rvalid", 64'(if_rvalid), 64'(e_irv));
            check("dm_rvalid", 64'(dm_rvalid), 64'(e_drv));
            check("if_rdata", 64'(if_rdata), 64'(last_if));
            check("dm_rdata", 64'(dm_rdata), 64'(last_dm));
            check("stall_if", 64'(stall_if), 64'(if_req & ~e_irv));
            check("stall_mem", 64'(stall_mem), 64'(dm_req & ~(e_drv | (e_dg & dm_we))));
`ifdef ARB_PERF_CNT_EN
            check("perf", 64'({perf_if_grants, perf_dm_grants, perf_conflicts}),
                  64'({16'(p_if), 16'(p_dm), 16'(p_cf)}));
            if (e_ig && p_if < 65535) p_if++;
            if (e_dg && p_dm < 65535) p_dm++;
            if (idle && if_req && dm_req && p_cf < 65535) p_cf++;
`else
            check("perf_tied", 64'({perf_if_grants, perf_dm_grants, perf_conflicts}), 64'd0);
`endif
            if (e_irv || e_drv) pend = 0;
            if (e_dg && dm_we) begin
                ref_mem[dm_addr] = {8'h00, dm_wdata};
                free_at = cyc + 1;
            end else if (e_ig || e_dg) begin
                pend = 1; pend_if = e_ig; due = cyc + 1; free_at = due + 1;
                pend_data = ref_mem[e_addr];
            end
            if (!if_req || e_ig) starve = 0;
            else if (e_dg && starve < LIMIT) starve++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       ig, dg;
    logic [5:0] win_pat;
    int         ngr;

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem1[a]    = pat(8'(a));
            ref_mem[a] = pat(8'(a));
        end
        mem1[8'h10] = 16'hABCD;
        ref_mem[8'h10] = 16'hABCD;

        // Reset with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_req = 1'($urandom); if_addr = 8'($urandom); dm_req = 1'($urandom);
            dm_we = 1'($urandom); dm_addr = 8'($urandom); dm_wdata = 8'($urandom);
            tick();
        end
        @(negedge clk);
        check("rst_gnt_literal", 64'({if_gnt, dm_gnt, mem_en, stall_if, stall_mem}), 64'd0);
        tick();
        if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("idle_no_mem_en", 64'(mem_en), 64'd0);

        // Fetch read.
        tick(); if_req = 1; if_addr = 8'h10;
        @(negedge clk);
        check("fetch_T", 64'({if_gnt, mem_en, mem_addr, stall_if}), 64'({1'b1, 1'b1, 8'h10, 1'b1}));
        tick();
        @(negedge clk);
        check("fetch_T1", 64'({if_rvalid, if_rdata, stall_if}), 64'({1'b1, 16'hABCD, 1'b0}));
        tick(); if_req = 0;

        // Conflict: data first, then fetch.
        @(negedge clk);
        tick(); dm_req = 1; dm_we = 0; dm_addr = 8'h20; if_req = 1; if_addr = 8'h30;
        @(negedge clk);
        check("conf_dm_gnt", 64'({dm_gnt, if_gnt}), 64'({1'b1, 1'b0}));
        tick(); dm_req = 0;
        @(negedge clk);
        check("conf_dm_rvalid", 64'({dm_rvalid, dm_rdata}), 64'({1'b1, 8'hDF}));
        @(negedge clk);
        check("conf_if_gnt", 64'({if_gnt, mem_addr}), 64'({1'b1, 8'h30}));
        tick(); if_req = 0;
        @(negedge clk);
        check("conf_if_rvalid", 64'({if_rvalid, if_rdata}), 64'({1'b1, 16'h30CF}));

        // Starvation guard.
        tick(); if_req = 1; if_addr = 8'h50; dm_req = 1; dm_we = 0; dm_addr = 8'h51;
        ngr = 0; win_pat = 6'd0;
        for (int k = 0; k < 60 && ngr < 6; k++) begin
            @(negedge clk);
            if (if_gnt) begin win_pat[ngr] = 1'b1; ngr++; end
            else if (dm_gnt) ngr++;
            tick();
        end
        if_req = 0; dm_req = 0;
        check("starve_grants_seen", 64'(ngr), 64'd6);
        check("starve_pattern", 64'(win_pat), 64'(6'b010000));

        // Single-cycle write, then read it back.
        repeat (3) tick();
        dm_req = 1; dm_we = 1; dm_addr = 8'h40; dm_wdata = 8'h5A;
        @(negedge clk);
        check("write_cycle", 64'({mem_we, mem_wdata, dm_gnt, stall_mem}), 64'({1'b1, 16'h005A, 1'b1, 1'b0}));
        tick(); dm_req = 0; dm_we = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("write_no_rvalid", 64'(dm_rvalid), 64'd0);
        end
        tick(); dm_req = 1; dm_addr = 8'h40;
        @(negedge clk);
        tick(); dm_req = 0;
        @(negedge clk);
        check("write_readback", 64'({dm_rvalid, dm_rdata}), 64'({1'b1, 8'h5A}));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); ig = if_gnt; dg = dm_gnt;
            tick();
            reset = ($urandom_range(0, 299) != 0);
            if (!if_req || ig) begin
                if_req = ($urandom_range(0, 9) < 6); if_addr = 8'($urandom_range(0, 31));
            end else if ($urandom_range(0, 19) == 0) if_req = 0;
            if (!dm_req || dg) begin
                dm_req = ($urandom_range(0, 9) < 6); dm_we = ($urandom_range(0, 2) == 0);
                dm_addr = 8'($urandom_range(0, 31)); dm_wdata = 8'($urandom);
            end else if ($urandom_range(0, 19) == 0) dm_req = 0;
        end
        tick(); reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
        repeat (6) tick();

        // Reset mid-read on the MEM_LAT=3 instance.
        if_req = 1; if_addr = 8'h60;
        @(negedge clk);
        check("midrst_gnt", 64'(u3_if_gnt), 64'd1);
        tick(); if_req = 0; reset = 0;
        tick(); tick(); reset = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_rvalid", 64'(u3_if_rvalid), 64'd0);
        end
`ifdef ARB_PERF_CNT_EN
        check("midrst_perf_zero", 64'({u3_perf_if, u3_perf_dm, u3_perf_cf}), 64'd0);
`endif
        tick(); if_req = 1; if_addr = 8'h61;
        @(negedge clk);
        check("midrst_regrant", 64'({u3_if_gnt, u3_mem_addr}), 64'({1'b1, 8'h61}));
        tick(); if_req = 0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 256x16 unified memory between the fetch stage (16-bit instruction reads) and the MEM stage (8-bit data reads and writes).
- Fixed priority to data, with a starvation guard that protects fetch.
- Sequences every memory access through a small FSM, returns read data with valid strobes, and generates per-requester stall signals for the hazard logic.

Parameters:
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (1..7)
STARVE_LIMIT, 4, consecutive arbitration losses by fetch before fetch is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  8  fetch address; sampled at grant
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  if_rdata valid (1-cycle pulse)
if_rdata  out  16  instruction word
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1=write, 0=read; sampled at grant
dm_addr  in  8  data address; sampled at grant
dm_wdata  in  8  write data; sampled at grant
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  dm_rdata valid (1-cycle pulse)
dm_rdata  out  8  low byte of read word
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  8  memory address
mem_wdata  out  16  {8'h00, dm_wdata}
mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  fetch must hold
stall_mem  out  1  MEM stage must hold
perf_if_grants  out  16  see Optional Feature
perf_dm_grants  out  16  see Optional Feature
perf_conflicts  out  16  see Optional Feature

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM.
- Reset (reset=0): state IDLE, starve count 0, latency count 0. Every output is 0.
- IDLE arbitration is combinational and happens in the same cycle as the request:
  - Only dm_req set: grant data.
  - Only if_req set: grant fetch.
  - Both set: grant data, unless the starve count equals STARVE_LIMIT, in which case grant fetch.
- Grant cycle:
  - Assert exactly one of if_gnt/dm_gnt, plus mem_en.
  - Drive mem_addr (and mem_we, mem_wdata for data writes) from the winner's inputs.
  - Latch owner and address.
- Data write: single cycle. mem_we=1, no rvalid, stay in IDLE. A new grant is possible next cycle.
- Read: go to BUSY_IF or BUSY_DM with the latency count loaded to MEM_LAT-1.
  - Each cycle in BUSY: decrement the count; when it is 0, capture mem_rdata.
  - Capture cycle: pulse if_rvalid with if_rdata=mem_rdata, or dm_rvalid with dm_rdata=mem_rdata[7:0]. Return to IDLE.
  - mem_en is 0 throughout BUSY.
- Read data outputs hold their last value between pulses.
- Starve count:
  - Increments (saturating at STARVE_LIMIT) in each IDLE cycle where if_req=1 and data is granted.
  - Clears when fetch is granted or when if_req=0.
- No arbitration happens in BUSY; requests stay pending.
- stall_if = if_req & ~if_rvalid. stall_mem = dm_req & ~(dm_rvalid | (dm_gnt & dm_we)).
- Read latency: rvalid arrives MEM_LAT cycles after gnt. Read throughput is one per MEM_LAT+1 cycles.
- Requester deasserting before gnt: the request is withdrawn, with no side effects.
- Reset asserted mid-transaction: the in-flight read is discarded, no rvalid is ever produced for it, and the FSM goes to IDLE.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - perf_if_grants / perf_dm_grants count grants per requester.
  - perf_conflicts counts IDLE cycles with if_req & dm_req both set.
  - All three are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: no counter logic; the three ports are tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0; after release with no requests, mem_en stays 0.
- Fetch read (MEM_LAT=1): if_req=1, if_addr=8'h10 at cycle T; memory returns 16'hABCD -> if_gnt, mem_en, mem_addr=8'h10 at T; if_rvalid=1, if_rdata=16'hABCD at T+1; stall_if=1 at T, 0 at T+1.
- Conflict: dm_req read 8'h20 and if_req 8'h30 at T -> dm_gnt at T, dm_rvalid at T+1; if_gnt at T+2 with mem_addr=8'h30; if_rvalid at T+3.
- Starvation (STARVE_LIMIT=4): dm_req reads and if_req held continuously -> data wins 4 arbitrations, fetch wins the 5th, data wins the 6th.
- Write: dm_req, dm_we=1, dm_addr=8'h40, dm_wdata=8'h5A -> mem_we=1, mem_wdata=16'h005A, dm_gnt=1 and stall_mem=0 the same cycle; dm_rvalid never set.
- Reset mid-read (MEM_LAT=3): assert reset one cycle after a fetch grant -> no if_rvalid ever appears; after release, FSM is IDLE and the next request is granted immediately; with ARB_PERF_CNT_EN, counters read 0.
